// File: rtl/id_pkg.sv
// id_pkg: shared constants for the ID/issue stage.
//   OpLen      - width of the internal micro-op code
//   OP_*       - micro-op encodings (loads contiguous, M-extension ops last)
//   OPC_*      - RV32I major opcodes
//   ZERO_WORD  - 32-bit zero used by decode defaults
package id_pkg;

  localparam int OpLen = 6;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [OpLen-1:0] OP_NOP    = 6'd0;
  localparam logic [OpLen-1:0] OP_LUI    = 6'd1;
  localparam logic [OpLen-1:0] OP_AUIPC  = 6'd2;
  localparam logic [OpLen-1:0] OP_JAL    = 6'd3;
  localparam logic [OpLen-1:0] OP_JALR   = 6'd4;
  localparam logic [OpLen-1:0] OP_BEQ    = 6'd5;
  localparam logic [OpLen-1:0] OP_BNE    = 6'd6;
  localparam logic [OpLen-1:0] OP_BLT    = 6'd7;
  localparam logic [OpLen-1:0] OP_BGE    = 6'd8;
  localparam logic [OpLen-1:0] OP_BLTU   = 6'd9;
  localparam logic [OpLen-1:0] OP_BGEU   = 6'd10;
  localparam logic [OpLen-1:0] OP_LB     = 6'd11;
  localparam logic [OpLen-1:0] OP_LH     = 6'd12;
  localparam logic [OpLen-1:0] OP_LW     = 6'd13;
  localparam logic [OpLen-1:0] OP_LBU    = 6'd14;
  localparam logic [OpLen-1:0] OP_LHU    = 6'd15;
  localparam logic [OpLen-1:0] OP_SB     = 6'd16;
  localparam logic [OpLen-1:0] OP_SH     = 6'd17;
  localparam logic [OpLen-1:0] OP_SW     = 6'd18;
  localparam logic [OpLen-1:0] OP_ADDI   = 6'd19;
  localparam logic [OpLen-1:0] OP_SLTI   = 6'd20;
  localparam logic [OpLen-1:0] OP_SLTIU  = 6'd21;
  localparam logic [OpLen-1:0] OP_XORI   = 6'd22;
  localparam logic [OpLen-1:0] OP_ORI    = 6'd23;
  localparam logic [OpLen-1:0] OP_ANDI   = 6'd24;
  localparam logic [OpLen-1:0] OP_SLLI   = 6'd25;
  localparam logic [OpLen-1:0] OP_SRLI   = 6'd26;
  localparam logic [OpLen-1:0] OP_SRAI   = 6'd27;
  localparam logic [OpLen-1:0] OP_ADD    = 6'd28;
  localparam logic [OpLen-1:0] OP_SUB    = 6'd29;
  localparam logic [OpLen-1:0] OP_SLL    = 6'd30;
  localparam logic [OpLen-1:0] OP_SLT    = 6'd31;
  localparam logic [OpLen-1:0] OP_SLTU   = 6'd32;
  localparam logic [OpLen-1:0] OP_XOR    = 6'd33;
  localparam logic [OpLen-1:0] OP_SRL    = 6'd34;
  localparam logic [OpLen-1:0] OP_SRA    = 6'd35;
  localparam logic [OpLen-1:0] OP_OR     = 6'd36;
  localparam logic [OpLen-1:0] OP_AND    = 6'd37;
  localparam logic [OpLen-1:0] OP_MUL    = 6'd38;
  localparam logic [OpLen-1:0] OP_MULH   = 6'd39;
  localparam logic [OpLen-1:0] OP_MULHSU = 6'd40;
  localparam logic [OpLen-1:0] OP_MULHU  = 6'd41;
  localparam logic [OpLen-1:0] OP_DIV    = 6'd42;
  localparam logic [OpLen-1:0] OP_DIVU   = 6'd43;
  localparam logic [OpLen-1:0] OP_REM    = 6'd44;
  localparam logic [OpLen-1:0] OP_REMU   = 6'd45;

endpackage

// File: rtl/id_decoder.sv
// id_decoder: purely combinational RV32I instruction decode.
// Optional feature: define ID_RV32M_EN to decode the RV32M multiply/divide ops;
// otherwise those encodings fall through to NOP.
// Ports:
//   inst - 32-bit instruction word
//   op   - micro-op code (OP_NOP for anything unrecognised)
//   rd   - destination register (0 for NOP, stores and branches)
//   imm  - sign-extended 32-bit immediate for the instruction format
//   rs1, rs2 - source register addresses
//   re1, re2 - source read enables
module id_decoder
  import id_pkg::*;
(
  input  logic [31:0]        inst,
  output logic [OpLen-1:0]   op,
  output logic [4:0]         rd,
  output logic signed [31:0] imm,
  output logic [4:0]         rs1,
  output logic [4:0]         rs2,
  output logic               re1,
  output logic               re2
);

  logic [6:0]         opc;
  logic [2:0]         f3;
  logic [6:0]         f7;
  logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opc   = inst[6:0];
  assign f3    = inst[14:12];
  assign f7    = inst[31:25];
  assign rs1   = inst[19:15];
  assign rs2   = inst[24:20];
  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'h000};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  // Each opcode sets its format fields; a funct3/funct7 that is not listed
  // leaves op at NOP and the cleanup at the end wipes the fields again.
  always_comb begin
    op  = OP_NOP;
    rd  = 5'd0;
    imm = ZERO_WORD;
    re1 = 1'b0;
    re2 = 1'b0;
    case (opc)
      OPC_LUI:   begin op = OP_LUI;   rd = inst[11:7]; imm = imm_u; end
      OPC_AUIPC: begin op = OP_AUIPC; rd = inst[11:7]; imm = imm_u; end
      OPC_JAL:   begin op = OP_JAL;   rd = inst[11:7]; imm = imm_j; end
      OPC_JALR: begin
        if (f3 == 3'd0) op = OP_JALR;
        rd = inst[11:7]; imm = imm_i; re1 = 1'b1;
      end
      OPC_BRANCH: begin
        case (f3)
          3'd0: op = OP_BEQ;
          3'd1: op = OP_BNE;
          3'd4: op = OP_BLT;
          3'd5: op = OP_BGE;
          3'd6: op = OP_BLTU;
          3'd7: op = OP_BGEU;
          default: op = OP_NOP;
        endcase
        imm = imm_b; re1 = 1'b1; re2 = 1'b1;
      end
      OPC_LOAD: begin
        case (f3)
          3'd0: op = OP_LB;
          3'd1: op = OP_LH;
          3'd2: op = OP_LW;
          3'd4: op = OP_LBU;
          3'd5: op = OP_LHU;
          default: op = OP_NOP;
        endcase
        rd = inst[11:7]; imm = imm_i; re1 = 1'b1;
      end
      OPC_STORE: begin
        case (f3)
          3'd0: op = OP_SB;
          3'd1: op = OP_SH;
          3'd2: op = OP_SW;
          default: op = OP_NOP;
        endcase
        imm = imm_s; re1 = 1'b1; re2 = 1'b1;
      end
      OPC_OPIMM: begin
        case (f3)
          3'd0: op = OP_ADDI;
          3'd2: op = OP_SLTI;
          3'd3: op = OP_SLTIU;
          3'd4: op = OP_XORI;
          3'd6: op = OP_ORI;
          3'd7: op = OP_ANDI;
          3'd1: op = (f7 == 7'b0000000) ? OP_SLLI : OP_NOP;
          3'd5: op = (f7 == 7'b0000000) ? OP_SRLI :
                     (f7 == 7'b0100000) ? OP_SRAI : OP_NOP;
          default: op = OP_NOP;
        endcase
        rd = inst[11:7]; imm = imm_i; re1 = 1'b1;
      end
      OPC_OP: begin
        if (f7 == 7'b0000000) begin
          case (f3)
            3'd0: op = OP_ADD;
            3'd1: op = OP_SLL;
            3'd2: op = OP_SLT;
            3'd3: op = OP_SLTU;
            3'd4: op = OP_XOR;
            3'd5: op = OP_SRL;
            3'd6: op = OP_OR;
            default: op = OP_AND;
          endcase
        end else if (f7 == 7'b0100000) begin
          if (f3 == 3'd0)      op = OP_SUB;
          else if (f3 == 3'd5) op = OP_SRA;
        end
`ifdef ID_RV32M_EN
        else if (f7 == 7'b0000001) begin
          case (f3)
            3'd0: op = OP_MUL;
            3'd1: op = OP_MULH;
            3'd2: op = OP_MULHSU;
            3'd3: op = OP_MULHU;
            3'd4: op = OP_DIV;
            3'd5: op = OP_DIVU;
            3'd6: op = OP_REM;
            default: op = OP_REMU;
          endcase
        end
`endif
        rd = inst[11:7]; re1 = 1'b1; re2 = 1'b1;
      end
      default: op = OP_NOP;
    endcase
    if (op == OP_NOP) begin
      rd  = 5'd0;
      imm = ZERO_WORD;
      re1 = 1'b0;
      re2 = 1'b0;
    end
  end

endmodule

// File: rtl/id_issue.sv
// id_issue: instruction decode / operand issue stage.
// Decodes the incoming instruction (id_decoder), resolves operands from the
// forwarding network or the register file, stalls on load-use hazards and
// presents a registered ID->EX bundle under a valid/ready handshake.
// Optional feature: define ID_RV32M_EN to decode RV32M ops (see id_decoder).
// Ports:
//   clk, rst (sync, active-high), rdy (global enable), flush (redirect)
//   in_valid/in_ready, pc, inst            - IF->ID
//   reg1_addr_o/reg2_addr_o, reg*_data_i   - register-file read
//   fwd_valid/fwd_is_load/fwd_addr/fwd_data - forwarding sources, 0 youngest
//   out_valid/out_ready, pc_o, reg1, reg2, imm, rd, op - ID->EX
//   stall_cnt                              - saturating hazard cycle count
module id_issue
  import id_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int NUM_FWD     = 2,
  parameter int STALL_CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [XLEN-1:0]           pc,
  input  logic [31:0]               inst,
  output logic [4:0]                reg1_addr_o,
  output logic [4:0]                reg2_addr_o,
  input  logic [XLEN-1:0]           reg1_data_i,
  input  logic [XLEN-1:0]           reg2_data_i,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  logic [NUM_FWD-1:0]        fwd_is_load,
  input  logic [NUM_FWD*5-1:0]      fwd_addr,
  input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           pc_o,
  output logic [XLEN-1:0]           reg1,
  output logic [XLEN-1:0]           reg2,
  output logic [XLEN-1:0]           imm,
  output logic [4:0]                rd,
  output logic [OpLen-1:0]          op,
  output logic [STALL_CNT_W-1:0]    stall_cnt
);

  // Returns {is_load, data}: zero for x0 or an unused source, otherwise the
  // youngest matching forward, otherwise the register file.
  function automatic logic [XLEN:0] pick_operand(
    input logic [4:0]              a,
    input logic                    en,
    input logic [XLEN-1:0]         rf,
    input logic [NUM_FWD-1:0]      fv,
    input logic [NUM_FWD-1:0]      fl,
    input logic [NUM_FWD*5-1:0]    fa,
    input logic [NUM_FWD*XLEN-1:0] fd
  );
    logic [XLEN:0] r;
    logic          hit;
    r   = {1'b0, rf};
    hit = 1'b0;
    for (int i = 0; i < NUM_FWD; i++) begin
      if (!hit && fv[i] && (fa[i*5 +: 5] == a)) begin
        hit = 1'b1;
        r   = {fl[i], fd[i*XLEN +: XLEN]};
      end
    end
    if (!en || (a == 5'd0)) r = '0;
    return r;
  endfunction

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [OpLen-1:0]   dec_op;
  logic [4:0]         dec_rd, dec_rs1, dec_rs2;
  logic signed [31:0] dec_imm;
  logic               dec_re1, dec_re2;
  logic [XLEN:0]      opnd1_p0, opnd2_p0;
  logic               hazard_p0, capture_p0;

  id_decoder u_dec (
    .inst (inst),
    .op   (dec_op),
    .rd   (dec_rd),
    .imm  (dec_imm),
    .rs1  (dec_rs1),
    .rs2  (dec_rs2),
    .re1  (dec_re1),
    .re2  (dec_re2)
  );

  // ---- stage p0: operand resolve, hazard, handshake ----
  assign reg1_addr_o = (rst || flush || !dec_re1) ? 5'd0 : dec_rs1;
  assign reg2_addr_o = (rst || flush || !dec_re2) ? 5'd0 : dec_rs2;

  assign opnd1_p0 = pick_operand(dec_rs1, dec_re1, reg1_data_i,
                                 fwd_valid, fwd_is_load, fwd_addr, fwd_data);
  assign opnd2_p0 = pick_operand(dec_rs2, dec_re2, reg2_data_i,
                                 fwd_valid, fwd_is_load, fwd_addr, fwd_data);

  assign hazard_p0  = in_valid && (opnd1_p0[XLEN] || opnd2_p0[XLEN]);
  assign in_ready   = rdy && !flush && !hazard_p0 && (!out_valid || out_ready);
  assign capture_p0 = in_valid && in_ready;

  // ---- stage p1: ID->EX registers ----
  logic                   vld_p1;
  logic [XLEN-1:0]        pc_p1, reg1_p1, reg2_p1, imm_p1;
  logic [4:0]             rd_p1;
  logic [OpLen-1:0]       op_p1;
  logic [STALL_CNT_W-1:0] stall_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      pc_p1    <= '0;
      reg1_p1  <= '0;
      reg2_p1  <= '0;
      imm_p1   <= '0;
      rd_p1    <= 5'd0;
      op_p1    <= OP_NOP;
      stall_p1 <= '0;
    end else if (rdy) begin
      if (flush) begin
        vld_p1 <= 1'b0;
      end else if (capture_p0) begin
        vld_p1  <= 1'b1;
        pc_p1   <= pc;
        reg1_p1 <= opnd1_p0[XLEN-1:0];
        reg2_p1 <= opnd2_p0[XLEN-1:0];
        imm_p1  <= XLEN'(dec_imm);
        rd_p1   <= dec_rd;
        op_p1   <= dec_op;
      end else if (vld_p1 && out_ready) begin
        vld_p1 <= 1'b0;
      end
      if (in_valid && hazard_p0 && !flush) stall_p1 <= sat_inc(stall_p1);
    end
  end

  assign out_valid = vld_p1;
  assign pc_o      = pc_p1;
  assign reg1      = reg1_p1;
  assign reg2      = reg2_p1;
  assign imm       = imm_p1;
  assign rd        = rd_p1;
  assign op        = op_p1;
  assign stall_cnt = stall_p1;

endmodule

// File: tb/tb_id_issue.sv
module tb_id_issue;
  import id_pkg::*;

  localparam int XLEN = 32;
  localparam int NF   = 2;

  logic              clk = 1'b0;
  logic              rst, rdy, flush, in_valid, out_ready;
  logic [XLEN-1:0]   pc, reg1_data_i, reg2_data_i;
  logic [31:0]       inst;
  logic [NF-1:0]     fwd_valid, fwd_is_load;
  logic [NF*5-1:0]   fwd_addr;
  logic [NF*XLEN-1:0] fwd_data;

  logic              in_ready, out_valid;
  logic [4:0]        reg1_addr_o, reg2_addr_o, rd;
  logic [XLEN-1:0]   pc_o, reg1, reg2, imm;
  logic [OpLen-1:0]  op;
  logic [15:0]       stall_cnt;

  // narrow-counter instance to reach saturation quickly
  logic              s_in_ready, s_out_valid;
  logic [4:0]        s_r1a, s_r2a, s_rd;
  logic [XLEN-1:0]   s_pc_o, s_reg1, s_reg2, s_imm;
  logic [OpLen-1:0]  s_op;
  logic [1:0]        s_stall_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  id_issue #(.XLEN(XLEN), .NUM_FWD(NF), .STALL_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .pc(pc), .inst(inst),
    .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .fwd_valid(fwd_valid), .fwd_is_load(fwd_is_load),
    .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .pc_o(pc_o), .reg1(reg1), .reg2(reg2), .imm(imm), .rd(rd), .op(op),
    .stall_cnt(stall_cnt)
  );

  id_issue #(.XLEN(XLEN), .NUM_FWD(NF), .STALL_CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .pc(pc), .inst(inst),
    .reg1_addr_o(s_r1a), .reg2_addr_o(s_r2a),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .fwd_valid(fwd_valid), .fwd_is_load(fwd_is_load),
    .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .pc_o(s_pc_o), .reg1(s_reg1), .reg2(s_reg2), .imm(s_imm), .rd(s_rd), .op(s_op),
    .stall_cnt(s_stall_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fwd(input logic [1:0] v, input logic [1:0] ld,
                         input logic [4:0] a0, input logic [31:0] d0,
                         input logic [4:0] a1, input logic [31:0] d1);
    fwd_valid   = v;
    fwd_is_load = ld;
    fwd_addr    = {a1, a0};
    fwd_data    = {d1, d0};
  endtask

  localparam logic [31:0] I_ADDI  = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] I_ADD   = 32'h0011_01B3; // add  x3,x2,x1
  localparam logic [31:0] I_ADDIN = 32'hFFF0_0293; // addi x5,x0,-1
  localparam logic [31:0] I_MUL   = 32'h0220_81B3; // mul  x3,x1,x2
  localparam logic [31:0] I_BAD   = 32'h0000_007F;
  localparam logic [31:0] I_LUI   = 32'h1234_53B7; // lui  x7,0x12345
  localparam logic [31:0] I_SW    = 32'h0020_A423; // sw   x2,8(x1)

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    pc = '0; inst = '0; reg1_data_i = '0; reg2_data_i = '0;
    set_fwd(2'b00, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);

    // reset state
    tick(); tick();
    chk("rst_vld", out_valid, 0);
    chk("rst_op", op, OP_NOP);
    chk("rst_stall", stall_cnt, 0);
    inst = I_ADD; #1;
    chk("rst_r1addr", reg1_addr_o, 0);

    // ADDI x1,x0,5
    rst = 1'b0; in_valid = 1'b1; inst = I_ADDI; pc = 32'h100; #1;
    chk("addi_inrdy", in_ready, 1);
    tick();
    chk("addi_vld", out_valid, 1);
    chk("addi_op", op, OP_ADDI);
    chk("addi_rd", rd, 1);
    chk("addi_imm", imm, 5);
    chk("addi_reg1", reg1, 0);
    chk("addi_pc", pc_o, 32'h100);

    // ADD x3,x2,x1 with both forwards hitting x2: youngest wins
    inst = I_ADD; pc = 32'h104; reg1_data_i = 32'h55; reg2_data_i = 32'd4;
    set_fwd(2'b11, 2'b00, 5'd2, 32'd7, 5'd2, 32'd9); #1;
    chk("add_r1addr", reg1_addr_o, 2);
    chk("add_r2addr", reg2_addr_o, 1);
    tick();
    chk("add_op", op, OP_ADD);
    chk("add_rd", rd, 3);
    chk("add_reg1", reg1, 7);
    chk("add_reg2", reg2, 4);
    set_fwd(2'b10, 2'b00, 5'd2, 32'd7, 5'd2, 32'd9);
    tick();
    chk("add_fwd1", reg1, 9);

    // load-use hazard for 3 cycles
    set_fwd(2'b01, 2'b01, 5'd2, 32'd0, 5'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("haz_inrdy", in_ready, 0);
      tick();
    end
    chk("haz_cnt", stall_cnt, 3);
    chk("haz_sat3", s_stall_cnt, 3);
    chk("haz_vld", out_valid, 0);
    set_fwd(2'b01, 2'b00, 5'd2, 32'h11, 5'd0, 32'd0);
    tick();
    chk("haz_cap_vld", out_valid, 1);
    chk("haz_cap_reg1", reg1, 32'h11);
    chk("haz_cnt_hold", stall_cnt, 3);

    // capture, backpressure 2 cycles, then flush
    inst = I_ADDIN; pc = 32'h200;
    tick();
    chk("neg_imm", imm, 32'hFFFF_FFFF);
    out_ready = 1'b0; inst = I_ADD; pc = 32'h204;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("bp_vld", out_valid, 1);
      chk("bp_rd", rd, 5);
      chk("bp_pc", pc_o, 32'h200);
    end
    flush = 1'b1; #1;
    chk("fl_inrdy", in_ready, 0);
    chk("fl_r1addr", reg1_addr_o, 0);
    tick();
    chk("fl_vld", out_valid, 0);
    chk("fl_rd", rd, 5);
    chk("fl_pc", pc_o, 32'h200);
    flush = 1'b0; out_ready = 1'b1;

    // MUL: M-extension dependent
    inst = I_MUL; pc = 32'h300;
    tick();
    chk("mul_vld", out_valid, 1);
`ifdef ID_RV32M_EN
    chk("mul_op", op, OP_MUL);
    chk("mul_rd", rd, 3);
`else
    chk("mul_op", op, OP_NOP);
    chk("mul_rd", rd, 0);
`endif

    // unknown opcode still captured as NOP
    inst = I_BAD; pc = 32'h304;
    tick();
    chk("bad_vld", out_valid, 1);
    chk("bad_op", op, OP_NOP);
    chk("bad_pc", pc_o, 32'h304);

    inst = I_LUI;
    tick();
    chk("lui_op", op, OP_LUI);
    chk("lui_imm", imm, 32'h1234_5000);
    chk("lui_rd", rd, 7);

    inst = I_SW;
    tick();
    chk("sw_op", op, OP_SW);
    chk("sw_imm", imm, 8);
    chk("sw_rd", rd, 0);

    // rdy low: everything holds
    rdy = 1'b0; inst = I_ADDI;
    tick();
    chk("rdy_op", op, OP_SW);
    chk("rdy_vld", out_valid, 1);
    rdy = 1'b1;

    // reset mid-stall
    set_fwd(2'b00, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    tick();
    out_ready = 1'b0; inst = I_ADD;
    set_fwd(2'b01, 2'b01, 5'd2, 32'd0, 5'd0, 32'd0);
    tick();
    chk("ms_cnt", stall_cnt, 4);
    chk("ms_sat", s_stall_cnt, 3);
    chk("ms_vld", out_valid, 1);
    rst = 1'b1; #1;
    chk("ms_r2addr", reg2_addr_o, 0);
    tick();
    chk("ms_rst_vld", out_valid, 0);
    chk("ms_rst_op", op, OP_NOP);
    chk("ms_rst_cnt", stall_cnt, 0);
    chk("ms_rst_bus", {pc_o, reg1} | {reg2, imm}, 0);
    chk("ms_rst_rd", rd, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_issue.md
ID_ISSUE -- requirements
Module: id_issue

Interface
REQ-001 SHALL have parameter XLEN, default 32, the operand/PC width.
REQ-002 SHALL have parameter NUM_FWD, default 2, the number of forwarding sources; index 0 is the youngest.
REQ-003 SHALL have parameter STALL_CNT_W, default 16, the hazard counter width.
REQ-004 SHALL have port clk  in  1  clock, the single clock of the block.
REQ-005 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port rdy  in  1  global enable; when low, all state holds.
REQ-007 SHALL have port flush  in  1  branch/jump redirect; kills the in-flight instruction.
REQ-008 SHALL have ports in_valid  in  1  and in_ready  out  1, the IF->ID handshake.
REQ-009 SHALL have ports pc  in  XLEN  and inst  in  32.
REQ-010 SHALL have ports reg1_addr_o and reg2_addr_o, each  out  5, plus reg1_data_i and reg2_data_i, each  in  XLEN, the register-file read.
REQ-011 SHALL have forwarding ports fwd_valid  in  NUM_FWD, fwd_is_load  in  NUM_FWD, fwd_addr  in  NUM_FWD*5  and fwd_data  in  NUM_FWD*XLEN.
REQ-012 SHALL have ports out_valid  out  1  and out_ready  in  1, the ID->EX handshake.
REQ-013 SHALL have registered outputs pc_o (XLEN), reg1 (XLEN), reg2 (XLEN), imm (XLEN), rd (5) and op (OpLen).
REQ-014 SHALL have port stall_cnt  out  STALL_CNT_W, a saturating count of hazard cycles.

Function
REQ-015 SHALL decode RV32I: LUI, AUIPC, JAL, JALR, branches, loads, stores, OP-IMM and OP; imm SHALL be sign-extended per format.
REQ-016 SHALL decode any unlisted opcode/funct3 to op=NOP with rd=0.
REQ-017 Operand selection per source SHALL follow this priority:
  - address x0 or read disabled -> 0;
  - otherwise the lowest-index fwd with fwd_valid and matching address;
  - otherwise the register file.
REQ-018 If the winning forward source has fwd_is_load=1, hazard SHALL be 1.
REQ-019 in_ready SHALL equal rdy & !flush & !hazard & (!out_valid | out_ready).
REQ-020 On in_valid & in_ready, the output registers SHALL load at the next edge with out_valid=1 (latency 1 cycle).
REQ-021 When out_valid & out_ready and no capture occurs, out_valid SHALL go to 0.
REQ-022 While out_valid & !out_ready, all outputs SHALL hold stable.
REQ-023 flush SHALL clear out_valid at the next edge and capture nothing; flush wins over a simultaneous capture.
REQ-024 reg1_addr_o and reg2_addr_o SHALL be 0 while flush or rst is asserted.
REQ-025 stall_cnt SHALL increment on each cycle with rdy & in_valid & hazard & !flush, and saturate at all-ones.
REQ-026 A decoded NOP SHALL still be captured with out_valid=1.

Reset
REQ-027 On rst, out_valid, pc_o, reg1, reg2, imm, rd and stall_cnt SHALL be 0 and op SHALL be NOP at the next edge.
REQ-028 rst SHALL take priority over flush and rdy; reset mid-stall SHALL drop the pending instruction.

Configuration
REQ-029 With ID_RV32M_EN defined, opcode 0110011 with funct7=0000001 SHALL decode to MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM or REMU by funct3.
REQ-030 Without ID_RV32M_EN, those encodings SHALL decode as NOP per REQ-016.

Structure
REQ-031 Package id_pkg SHALL hold OpLen, the op encodings (loads ordered contiguously, M ops appended last), the opcode constants and ZERO_WORD.
REQ-032 Combinational decode SHALL live in sub-module id_decoder; id_issue SHALL hold forwarding, hazard, handshake and registers.

Verification
REQ-033 ADDI x1,x0,5 (0x00500093), in_valid=1, out_ready=1 -> next cycle out_valid=1, op=ADDI, rd=1, imm=5, reg1=0.
REQ-034 ADD x3,x2,x1 (0x001101B3) with fwd0 {valid, addr=2, data=7} and fwd1 {valid, addr=2, data=9}, reg2_data_i=4 -> reg1=7, reg2=4.
REQ-035 Same ADD with fwd0 {valid, is_load, addr=2} for 3 cycles -> in_ready=0 for 3 cycles, stall_cnt=3, then capture once the load clears.
REQ-036 Capture followed by out_ready=0 for 2 cycles, then flush -> outputs hold for 2 cycles, then out_valid=0 and nothing captured in the flush cycle.
REQ-037 MUL x3,x1,x2 (0x022081B3) -> op=MUL with ID_RV32M_EN defined, op=NOP without it.
REQ-038 rst asserted while out_valid=1 and hazard=1 -> next cycle every output is zero/NOP and stall_cnt=0.
